// File: rtl/knn_axis_result_packer_pkg.sv
// ----------------------------------------------------------------------------
// knn_axis_result_packer_pkg
// Shared definitions for the KNN result packer: stream and name widths, the
// beat-state encoding and small width helpers used to size pointers, the
// level counter and the per-packet result index.
// ----------------------------------------------------------------------------
package knn_axis_result_packer_pkg;

   localparam int AXIS_DATA_W = 32;
   localparam int NAME_W      = 32;

   typedef enum logic [0:0] {
      BEAT_NAME  = 1'b0,
      BEAT_VALUE = 1'b1
   } beat_state_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int span;
      result = 32'sd0;
      span   = 32'sd1;
      while (span < value) begin
         span   = span * 32'sd2;
         result = result + 32'sd1;
      end
      return result;
   endfunction

   // Counter width that never collapses to zero bits.
   function automatic int min_one_w(input int count);
      return (clog2(count) > 32'sd0) ? clog2(count) : 32'sd1;
   endfunction

   // One FIFO entry holds {name, value}.
   function automatic int result_w(input int data_width);
      return NAME_W + data_width;
   endfunction

endpackage

// File: rtl/knn_axis_result_packer_if.sv
// ----------------------------------------------------------------------------
// knn_axis_result_packer_if
// 32-bit AXI4-Stream bundle (tdata/tvalid/tlast forward, tready backward).
//   master : drives tdata, tvalid, tlast; samples tready
//   slave  : samples tdata, tvalid, tlast; drives tready
// ----------------------------------------------------------------------------
interface knn_axis_result_packer_if;
   import knn_axis_result_packer_pkg::*;

   logic [AXIS_DATA_W-1:0] tdata;
   logic                   tvalid;
   logic                   tready;
   logic                   tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/knn_axis_result_packer_fifo.sv
// ----------------------------------------------------------------------------
// knn_axis_result_packer_fifo
// Register-based first-word-fall-through FIFO for packed {name, value} results.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and entry
//   pop        : remove head (ignored when empty)
//   dout       : current head entry (valid while !empty)
//   full/empty : level == DEPTH / level == 0
//   level      : entries held
// A push while full is still taken when a pop happens on the same edge, since
// the popped slot is exactly the one the write pointer addresses.
// ----------------------------------------------------------------------------
module knn_axis_result_packer_fifo
   import knn_axis_result_packer_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(DEPTH):0]  level
);

   localparam int PTR_W = min_one_w(DEPTH);
   localparam int LVL_W = clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Explicit wrap keeps non-power-of-two and single-entry depths correct.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == LAST_PTR) begin
         nxt = '0;
      end else begin
         nxt = ptr + PTR_W'(1'b1);
      end
      return nxt;
   endfunction

   assign full      = (level_q == FULL_LVL);
   assign empty     = (level_q == '0);
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);
   assign dout      = mem_q[rd_ptr_q];
   assign level     = level_q;

   // Next storage, pointers and occupancy from the accepted push/pop pair.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   level_d = level_q + LVL_W'(1'b1);
         2'b01:   level_d = level_q - LVL_W'(1'b1);
         default: level_d = level_q;
      endcase
   end

   // FIFO state registers; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/knn_axis_result_packer.sv
// ----------------------------------------------------------------------------
// knn_axis_result_packer
// Buffers {name, value} results strobed out of the KNN sorter and serialises
// each one as two AXI4-Stream beats (name, then zero-extended value). The
// value beat of every K-th result carries tlast.
//   mclk, reset_n              : clock, asynchronous active-low reset
//   AXIS_out_wr_en             : one-cycle strobe qualifying the result inputs
//   dataNameOut, dataValueOut  : result name and value from the sorter
//   m_axis                     : AXI4-Stream master (tdata/tvalid/tready/tlast)
//   overflow                   : sticky, a strobe was dropped on a full FIFO
//   level                      : results currently buffered
// ----------------------------------------------------------------------------
module knn_axis_result_packer
   import knn_axis_result_packer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int K          = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        mclk,
   input  logic                        reset_n,
   input  logic                        AXIS_out_wr_en,
   input  logic [NAME_W-1:0]           dataNameOut,
   input  logic [DATA_WIDTH-1:0]       dataValueOut,
   knn_axis_result_packer_if.master    m_axis,
   output logic                        overflow,
   output logic [clog2(FIFO_DEPTH):0]  level
);

   localparam int RESULT_W = result_w(DATA_WIDTH);
   localparam int IDX_W    = min_one_w(K);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

   beat_state_e              state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic                     overflow_q, overflow_d;
   logic                     full_s, empty_s, pop_s, drop_s;
   logic [RESULT_W-1:0]      head_s;
   logic [AXIS_DATA_W-1:0]   head_name_s, head_value_s;
   logic [AXIS_DATA_W-1:0]   tdata_s;
   logic                     tvalid_s, tlast_s;

   knn_axis_result_packer_fifo #(
      .WIDTH (RESULT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (mclk),
      .rst_n (reset_n),
      .push  (AXIS_out_wr_en),
      .pop   (pop_s),
      .din   ({dataNameOut, dataValueOut}),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s),
      .level (level)
   );

   assign head_name_s = head_s[RESULT_W-1 -: NAME_W];

   // Zero-extend the head value onto the stream width.
   always_comb begin
      head_value_s                   = '0;
      head_value_s[DATA_WIDTH-1:0]   = head_s[DATA_WIDTH-1:0];
   end

   // The head is only consumed by the VALUE handshake; VALUE implies non-empty.
   assign pop_s  = (state_q == BEAT_VALUE) && m_axis.tready;
   assign drop_s = AXIS_out_wr_en && full_s && !pop_s;

   // Stream outputs decoded from registered state and the registered FIFO head.
   always_comb begin
      tvalid_s = 1'b0;
      tdata_s  = '0;
      tlast_s  = 1'b0;
      case (state_q)
         BEAT_NAME: begin
            tvalid_s = !empty_s;
            tdata_s  = head_name_s;
            tlast_s  = 1'b0;
         end
         BEAT_VALUE: begin
            tvalid_s = 1'b1;
            tdata_s  = head_value_s;
            tlast_s  = (idx_q == LAST_IDX);
         end
         default: begin
            tvalid_s = 1'b0;
            tdata_s  = '0;
            tlast_s  = 1'b0;
         end
      endcase
   end

   // Beat sequencing, per-packet result index and sticky overflow.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      overflow_d = overflow_q | drop_s;
      case (state_q)
         BEAT_NAME: begin
            if (tvalid_s && m_axis.tready) begin
               state_d = BEAT_VALUE;
            end else begin
               state_d = BEAT_NAME;
            end
         end
         BEAT_VALUE: begin
            if (m_axis.tready) begin
               state_d = BEAT_NAME;
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1'b1);
               end
            end else begin
               state_d = BEAT_VALUE;
               idx_d   = idx_q;
            end
         end
         default: begin
            state_d = BEAT_NAME;
            idx_d   = '0;
         end
      endcase
   end

   // Beat FSM, index and overflow registers.
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= BEAT_NAME;
         idx_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
      end
   end

   assign m_axis.tvalid = tvalid_s;
   assign m_axis.tdata  = tdata_s;
   assign m_axis.tlast  = tlast_s;
   assign overflow      = overflow_q;

endmodule
